// File: rtl/sdm_tx_arb.sv
// Round-robin arbiter feeding one sdm_tx modulator: grants a producer, latches its sample, toggles push, tracks empty.
// Optional handshake watchdog enabled by defining SDM_TX_ARB_TIMEOUT_EN.
module sdm_tx_arb #(
    parameter int NCH  = 4,
    parameter int DMSB = 3,
    parameter int TMSB = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NCH-1:0]            req,
    input  logic [NCH*(DMSB+1)-1:0]   req_data,
    output logic [NCH-1:0]            ack,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic signed [DMSB:0]      sdm_wdata,
    output logic                      sdm_push,
    output logic                      sdm_clear,
    input  logic                      sdm_empty,
    output logic                      err,
    input  logic                      err_clr
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] ST_INIT       = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_PUSH       = 3'd2;
    localparam logic [2:0] ST_WAIT_TAKE  = 3'd3;
    localparam logic [2:0] ST_WAIT_EMPTY = 3'd4;

    logic [2:0]            state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_next;
    logic [1:0]            empty_sync;
    logic                  empty_s;
    logic                  win_found;
    logic [2:0]            win_idx;
    logic [NCH-1:0]        win_oh;
    logic signed [DMSB:0]  win_data;
    int                    idx;
    logic                  timeout;

    // sdm_empty comes from the modulator's own timing; never look at it raw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_sync <= 2'b11;
        end else begin
            empty_sync <= {empty_sync[0], sdm_empty};
        end
    end

    assign empty_s = empty_sync[1];

    // Scan downwards so the candidate nearest to ptr is assigned last and wins.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_data  = '0;
        idx       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NCH;
            if (req[idx]) begin
                win_found     = 1'b1;
                win_idx       = 3'(idx);
                win_oh        = '0;
                win_oh[idx]   = 1'b1;
                win_data      = req_data[idx*(DMSB+1) +: DMSB+1];
            end
        end
    end

    assign ptr_next = (grant_id == 3'(NCH - 1)) ? '0 : PW'(grant_id + 3'd1);

`ifdef SDM_TX_ARB_TIMEOUT_EN
    logic [TMSB:0] to_cnt;

    assign timeout = ((state == ST_WAIT_TAKE) || (state == ST_WAIT_EMPTY)) && (&to_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == ST_PUSH) begin
                to_cnt <= '0;
            end else if ((state == ST_WAIT_TAKE) || (state == ST_WAIT_EMPTY)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    localparam int unused_tmsb = TMSB;
    logic unused_err_clr;

    assign timeout        = 1'b0;
    assign err            = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            ptr       <= '0;
            ack       <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            sdm_wdata <= '0;
            sdm_push  <= 1'b0;
            sdm_clear <= 1'b0;
        end else begin
            ack       <= '0;
            sdm_clear <= 1'b0;
            case (state)
                ST_INIT: begin
                    sdm_clear <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (enable && win_found && empty_s) begin
                        sdm_wdata <= win_data;
                        ack       <= win_oh;
                        grant_id  <= win_idx;
                        busy      <= 1'b1;
                        state     <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    // wdata was registered last edge, so it is stable before this toggle.
                    sdm_push <= ~sdm_push;
                    state    <= ST_WAIT_TAKE;
                end
                ST_WAIT_TAKE: begin
                    if (!empty_s) begin
                        state <= ST_WAIT_EMPTY;
                    end
                end
                ST_WAIT_EMPTY: begin
                    if (empty_s) begin
                        busy  <= 1'b0;
                        ptr   <= ptr_next;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
            // A stalled modulator is flushed and the arbiter moves on to the next channel.
            if (timeout) begin
                sdm_clear <= 1'b1;
                busy      <= 1'b0;
                ptr       <= ptr_next;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sdm_tx_arb.sv
// Directed bench for sdm_tx_arb (NCH=4, DMSB=3, TMSB=3); the sdm_tx empty flag is driven by hand.
// The watchdog steps run only when SDM_TX_ARB_TIMEOUT_EN is defined.
module tb_sdm_tx_arb;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic signed [3:0] sdm_wdata;
    logic        sdm_push;
    logic        sdm_clear;
    logic        sdm_empty;
    logic        err;
    logic        err_clr;

    int   vectors;
    int   miscompares;
    logic exp_push;

    sdm_tx_arb #(.NCH(4), .DMSB(3), .TMSB(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .sdm_wdata (sdm_wdata),
        .sdm_push  (sdm_push),
        .sdm_clear (sdm_clear),
        .sdm_empty (sdm_empty),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted away from a clock edge, so the zero outputs are checked asynchronously.
    task automatic do_reset();
        rst       = 1'b1;
        sdm_empty = 1'b1;
        exp_push  = 1'b0;
        #2;
        check("rst_ack",      {28'b0, ack},       32'd0);
        check("rst_busy",     {31'b0, busy},      32'd0);
        check("rst_push",     {31'b0, sdm_push},  32'd0);
        check("rst_wdata",    {28'b0, sdm_wdata}, 32'd0);
        check("rst_grant_id", {29'b0, grant_id},  32'd0);
        check("rst_clear",    {31'b0, sdm_clear}, 32'd0);
        check("rst_err",      {31'b0, err},       32'd0);
        check("rst_ptr",      {30'b0, dut.ptr},   32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("init_clear",   {31'b0, sdm_clear}, 32'd1);
        check("init_state",   {29'b0, dut.state}, 32'd1);
        check("init_ack",     {28'b0, ack},       32'd0);
        check("init_busy",    {31'b0, busy},      32'd0);
    endtask

    // Grant edge followed by the push-toggle edge.
    task automatic t_grant(input int ch, input logic [3:0] d);
        tick();
        check("grant_ack",   {28'b0, ack},       32'(1) << ch);
        check("grant_wdata", {28'b0, sdm_wdata}, {28'b0, d});
        check("grant_id",    {29'b0, grant_id},  32'(ch));
        check("grant_busy",  {31'b0, busy},      32'd1);
        check("push_hold",   {31'b0, sdm_push},  {31'b0, exp_push});
        tick();
        exp_push = ~exp_push;
        check("push_toggle", {31'b0, sdm_push},  {31'b0, exp_push});
        check("ack_pulse",   {28'b0, ack},       32'd0);
    endtask

    // sdm_tx takes the word (empty falls) and later drains it (empty rises).
    task automatic t_complete();
        sdm_empty = 1'b0;
        repeat (4) tick();
        check("busy_take", {31'b0, busy}, 32'd1);
        sdm_empty = 1'b1;
        repeat (2) tick();
        check("busy_sync", {31'b0, busy}, 32'd1);
        tick();
        check("busy_fall", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0] rr_data [4];
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        req         = '0;
        req_data    = '0;
        sdm_empty   = 1'b1;
        err_clr     = 1'b0;
        exp_push    = 1'b0;
        #1;

        // Reset release and single clear pulse.
        do_reset();
        tick();
        check("clear_once", {31'b0, sdm_clear}, 32'd0);
        check("idle_ack",   {28'b0, ack},       32'd0);

        // Single requester on channel 2.
        enable   = 1'b1;
        req      = 4'b0100;
        req_data = {4'd0, 4'd5, 4'd0, 4'd0};
        t_grant(2, 4'd5);
        req = 4'b0000;
        t_complete();
        check("ptr_after_ch2", {30'b0, dut.ptr}, 32'd3);

        // All four requesting from a fresh pointer: 0,1,2,3,0.
        do_reset();
        rr_data[0] = 4'h3;
        rr_data[1] = 4'h8;
        rr_data[2] = 4'h7;
        rr_data[3] = 4'hF;
        req_data   = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
        req        = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            t_grant(i % 4, rr_data[i % 4]);
            t_complete();
        end
        check("rr_err", {31'b0, err}, 32'd0);

        // enable falls mid-transaction: it completes, then no grants until enable returns.
        req = 4'b0011;
        t_grant(1, 4'h8);
        t_complete();
        t_grant(0, 4'h3);
        enable = 1'b0;
        t_complete();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("disabled_ack",  {28'b0, ack},  32'd0);
            check("disabled_busy", {31'b0, busy}, 32'd0);
        end
        enable = 1'b1;
        t_grant(1, 4'h8);
        t_complete();

        // Reset hits while waiting for empty.
        req = 4'b1011;
        t_grant(3, 4'hF);
        sdm_empty = 1'b0;
        repeat (4) tick();
        check("pre_rst_state", {29'b0, dut.state}, 32'd4);
        check("pre_rst_push",  {31'b0, sdm_push},  32'd1);
        enable = 1'b0;
        do_reset();
        tick();
        check("post_rst_clear", {31'b0, sdm_clear}, 32'd0);
        check("post_rst_ack",   {28'b0, ack},       32'd0);

`ifdef SDM_TX_ARB_TIMEOUT_EN
        // Modulator never takes the word: watchdog fires, flushes and moves on.
        req    = 4'b0011;
        enable = 1'b1;
        t_grant(0, 4'h3);
        repeat (15) tick();
        check("to_err_before",  {31'b0, err},       32'd0);
        check("to_busy_before", {31'b0, busy},      32'd1);
        tick();
        check("to_err",   {31'b0, err},       32'd1);
        check("to_clear", {31'b0, sdm_clear}, 32'd1);
        check("to_busy",  {31'b0, busy},      32'd0);
        check("to_ptr",   {30'b0, dut.ptr},   32'd1);
        t_grant(1, 4'h8);
        check("to_err_sticky", {31'b0, err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", {31'b0, err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
